// File: rtl/cout_dec_pkg.sv
// Shared types for the carry-pulse period decoder: default width, period type,
// per-channel measurement states and the comparator flag bundle.
package cout_dec_pkg;

  localparam int unsigned W_DEFAULT = 10;
  localparam int unsigned PERIOD_W  = W_DEFAULT;

  typedef bit [PERIOD_W-1:0] period_t;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } meas_state_e;

  // Magnitude relation of channel A against channel B; one-hot when evaluated
  typedef struct packed {
    logic eq;
    logic a_gt;
    logic b_gt;
  } cmp_flags_t;

endpackage : cout_dec_pkg

// File: rtl/cout_period_decoder_if.sv
// Pulse inputs and recovered-modulus outputs of the period decoder.
// The slave side is the decoder; the master side drives pulses and observes results.
interface cout_period_decoder_if
  import cout_dec_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) ();

  logic         inA;
  logic         inB;
  logic [W-1:0] modA;
  logic [W-1:0] modB;
  logic         validA;
  logic         validB;
  logic         stableA;
  logic         stableB;
  logic         ovfA;
  logic         ovfB;
  logic         AeqB;
  logic         AmB;
  logic         BmA;

  modport master (
    output inA, inB,
    input  modA, modB, validA, validB, stableA, stableB, ovfA, ovfB, AeqB, AmB, BmA
  );

  modport slave (
    input  inA, inB,
    output modA, modB, validA, validB, stableA, stableB, ovfA, ovfB, AeqB, AmB, BmA
  );

endinterface : cout_period_decoder_if

// File: rtl/pulse_period_meter.sv
// Measures the number of clock cycles between consecutive pulses on one channel,
// reporting the last period, a two-in-a-row stability flag and a sticky overflow.
module pulse_period_meter
  import cout_dec_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         in,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         stable,
  output logic         ovf
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = '1;

  meas_state_e  state, state_d;
  logic [W-1:0] cnt, cnt_d;
  logic [W-1:0] period_d;
  logic         valid_d;
  logic         stable_d;
  logic         ovf_d;

  // State and result registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT_FIRST;
      cnt    <= '0;
      period <= '0;
      valid  <= 1'b0;
      stable <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      period <= period_d;
      valid  <= valid_d;
      stable <= stable_d;
      ovf    <= ovf_d;
    end
  end

  // Next-state and result update; everything holds unless a rule fires
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    period_d = period;
    valid_d  = valid;
    stable_d = stable;
    ovf_d    = ovf;
    case (state)
      WAIT_FIRST: begin
        if (in) begin
          cnt_d   = CNT_ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (in) begin
          // Stability compares against the period being replaced
          stable_d = valid && (cnt == period);
          period_d = cnt;
          valid_d  = 1'b1;
          ovf_d    = 1'b0;
          cnt_d    = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_ONE;
        end else begin
          // Gap too long to represent: drop the measurement, keep the old period
          ovf_d    = 1'b1;
          valid_d  = 1'b0;
          stable_d = 1'b0;
          cnt_d    = '0;
          state_d  = WAIT_FIRST;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

endmodule : pulse_period_meter

// File: rtl/cout_period_decoder.sv
// Recovers the modulus behind two carry-pulse streams and compares them,
// with the comparison registered one cycle behind the period registers.
module cout_period_decoder
  import cout_dec_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  cout_period_decoder_if.slave  bus
);

  cmp_flags_t cmp_q, cmp_d;

  pulse_period_meter #(.W(W)) u_meter_a (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .in     (bus.inA),
    .period (bus.modA),
    .valid  (bus.validA),
    .stable (bus.stableA),
    .ovf    (bus.ovfA)
  );

  pulse_period_meter #(.W(W)) u_meter_b (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .in     (bus.inB),
    .period (bus.modB),
    .valid  (bus.validB),
    .stable (bus.stableB),
    .ovf    (bus.ovfB)
  );

  // Three-way compare, only meaningful once both channels hold a measurement
  always_comb begin
    cmp_d = '0;
    if (bus.validA && bus.validB) begin
      cmp_d.eq   = (bus.modA == bus.modB);
      cmp_d.a_gt = (bus.modA >  bus.modB);
      cmp_d.b_gt = (bus.modB >  bus.modA);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= '0;
    end else begin
      cmp_q <= cmp_d;
    end
  end

  assign bus.AeqB = cmp_q.eq;
  assign bus.AmB  = cmp_q.a_gt;
  assign bus.BmA  = cmp_q.b_gt;

endmodule : cout_period_decoder

// File: tb/tb_cout_period_decoder.sv
// Self-checking bench for cout_period_decoder against a pulse-timestamp reference model.
module tb_cout_period_decoder;

  localparam int unsigned W       = 10;
  localparam int unsigned MAX_GAP = (1 << W) - 1;
  localparam int unsigned VW      = 2 * W + 9;

  logic CLK;
  logic rst_n;
  int   total;
  int   bad;

  cout_period_decoder_if #(.W(W)) bus ();

  cout_period_decoder #(.W(W)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: each channel remembers when it last pulsed
  int cyc;
  bit started [2];
  int last    [2];
  int per     [2];
  bit val     [2];
  bit stb     [2];
  bit ovf     [2];
  bit ceq, cgt, clt;

  function automatic void model_reset();
    cyc = 0;
    for (int c = 0; c < 2; c++) begin
      started[c] = 0; last[c] = 0; per[c] = 0;
      val[c] = 0; stb[c] = 0; ovf[c] = 0;
    end
    ceq = 0; cgt = 0; clt = 0;
  endfunction

  function automatic void chan_step(input int c, input bit p);
    int gap;
    if (!started[c]) begin
      if (p) begin
        started[c] = 1;
        last[c]    = cyc;
      end
    end else begin
      gap = cyc - last[c];
      if (p) begin
        stb[c]  = val[c] && (gap == per[c]);
        per[c]  = gap;
        val[c]  = 1;
        ovf[c]  = 0;
        last[c] = cyc;
      end else if (gap >= int'(MAX_GAP)) begin
        ovf[c]     = 1;
        val[c]     = 0;
        stb[c]     = 0;
        started[c] = 0;
      end
    end
  endfunction

  function automatic void model_step(input bit a, input bit b);
    cyc++;
    ceq = val[0] && val[1] && (per[0] == per[1]);
    cgt = val[0] && val[1] && (per[0] >  per[1]);
    clt = val[0] && val[1] && (per[1] >  per[0]);
    chan_step(0, a);
    chan_step(1, b);
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.modA, bus.modB, bus.validA, bus.validB, bus.stableA, bus.stableB,
            bus.ovfA, bus.ovfB, bus.AeqB, bus.AmB, bus.BmA};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {W'(per[0]), W'(per[1]), val[0], val[1], stb[0], stb[1],
            ovf[0], ovf[1], ceq, cgt, clt};
  endfunction

  task automatic tick(input bit a, input bit b);
    bus.inA = a;
    bus.inB = b;
    @(posedge CLK);
    model_step(a, b);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.inA = 1'b0;
    bus.inB = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs_vec() !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", obs_vec());
    end
    for (int i = 0; i < 3; i++) begin
      tick(i == 1, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL reset_first_pulse i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_matched();
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      tick(i % 7 == 0, i % 7 == 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL matched i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 7) begin
        total++;
        if ({bus.modA, bus.modB, bus.validA, bus.validB} !== {W'(7), W'(7), 2'b11}) begin
          bad++;
          $display("FAIL matched_mod modA=%0d modB=%0d vA=%b vB=%b exp 7 7 1 1",
                   bus.modA, bus.modB, bus.validA, bus.validB);
        end
      end
      if (i == 8) begin
        total++;
        if ({bus.AeqB, bus.AmB, bus.BmA} !== 3'b100) begin
          bad++;
          $display("FAIL matched_eq got=%b exp=100", {bus.AeqB, bus.AmB, bus.BmA});
        end
      end
      if (i == 14) begin
        total++;
        if ({bus.stableA, bus.stableB} !== 2'b11) begin
          bad++;
          $display("FAIL matched_stable got=%b exp=11", {bus.stableA, bus.stableB});
        end
      end
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs_vec() !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", obs_vec());
    end
    model_reset();
    bus.inA = 1'b0;
    bus.inB = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick(i % 3 == 0, i == 0 || i == 5);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL after_reset i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_unequal();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      tick(i % 5 == 0, i % 12 == 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL unequal i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if ({bus.modA, bus.modB, bus.AeqB, bus.AmB, bus.BmA} !== {W'(5), W'(12), 3'b001}) begin
      bad++;
      $display("FAIL unequal_bma modA=%0d modB=%0d cmp=%b exp 5 12 001",
               bus.modA, bus.modB, {bus.AeqB, bus.AmB, bus.BmA});
    end
    for (int i = 0; i < 60; i++) begin
      tick(i % 12 == 0, i % 5 == 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL swapped i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if ({bus.modA, bus.modB, bus.AeqB, bus.AmB, bus.BmA} !== {W'(12), W'(5), 3'b010}) begin
      bad++;
      $display("FAIL swapped_amb modA=%0d modB=%0d cmp=%b exp 12 5 010",
               bus.modA, bus.modB, {bus.AeqB, bus.AmB, bus.BmA});
    end
  endtask

  task automatic test_modulus_one();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL mod1 i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    total++;
    if ({bus.modA, bus.validA, bus.stableA} !== {W'(1), 2'b11}) begin
      bad++;
      $display("FAIL mod1_stable modA=%0d vA=%b sA=%b exp 1 1 1",
               bus.modA, bus.validA, bus.stableA);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= 2065; i++) begin
      tick(i == 0 || i == 10 || i == 1040 || i == 2063, i % 3 == 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL overflow i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 1032) begin
        total++;
        if ({bus.ovfA, bus.validA} !== 2'b01) begin
          bad++;
          $display("FAIL ovf_edge_before got ovf,valid=%b exp=01", {bus.ovfA, bus.validA});
        end
      end
      if (i == 1033) begin
        total++;
        if ({bus.ovfA, bus.validA, bus.stableA, bus.modA} !== {3'b100, W'(10)}) begin
          bad++;
          $display("FAIL ovf_set got ovf,valid,stable=%b modA=%0d exp=100 10",
                   {bus.ovfA, bus.validA, bus.stableA}, bus.modA);
        end
      end
      if (i == 1034) begin
        total++;
        if ({bus.AeqB, bus.AmB, bus.BmA} !== 3'b000) begin
          bad++;
          $display("FAIL ovf_cmp got=%b exp=000", {bus.AeqB, bus.AmB, bus.BmA});
        end
      end
      if (i == 2063) begin
        total++;
        if ({bus.modA, bus.ovfA, bus.validA} !== {W'(MAX_GAP), 2'b01}) begin
          bad++;
          $display("FAIL max_gap modA=%0d ovf=%b valid=%b exp 1023 0 1",
                   bus.modA, bus.ovfA, bus.validA);
        end
      end
    end
  endtask

  task automatic test_rate_change();
    do_reset();
    for (int i = 0; i <= 37; i++) begin
      tick(i inside {0, 9, 18, 27, 31, 35}, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rate i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i == 31) begin
        total++;
        if ({bus.modA, bus.stableA} !== {W'(4), 1'b0}) begin
          bad++;
          $display("FAIL rate_first modA=%0d sA=%b exp 4 0", bus.modA, bus.stableA);
        end
      end
      if (i == 35) begin
        total++;
        if ({bus.modA, bus.stableA} !== {W'(4), 1'b1}) begin
          bad++;
          $display("FAIL rate_second modA=%0d sA=%b exp 4 1", bus.modA, bus.stableA);
        end
      end
    end
  endtask

  task automatic test_random();
    int pa, pb, ja, jb;
    do_reset();
    for (int seg = 0; seg < 16; seg++) begin
      pa = $urandom_range(1, 30);
      pb = (seg % 4 == 0) ? pa : $urandom_range(1, 30);
      ja = $urandom_range(0, 3);
      jb = $urandom_range(0, 3);
      for (int i = 0; i < 200; i++) begin
        tick((i % pa == 0) || ($urandom_range(0, 63) < ja),
             (i % pb == 0) || ($urandom_range(0, 63) < jb));
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++;
          $display("FAIL random seg=%0d i=%0d got=%h exp=%h", seg, i, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.inA = 1'b0;
    bus.inB = 1'b0;
    model_reset();
    test_reset();
    test_matched();
    test_async_reset();
    test_unequal();
    test_modulus_one();
    test_overflow();
    test_rate_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cout_period_decoder

// File: doc/cout_period_decoder.md
Name: cout_period_decoder

Overview:
- Receive-side counterpart of the modulo-counter pair: consumes two carry-pulse streams (inA, inB) and recovers the modulus that produced each one.
- Per channel: measures the number of CLK cycles between consecutive pulses, flags a stable lock and overflow.
- Registered magnitude compare of the two recovered moduli.
- Sits downstream of the counter/FSM cluster as a self-check and monitoring block.

Parameters:
- W, 10, width of the recovered modulus and of the interval counter; max measurable period 2^W-1.

Ports:
- CLK  input  1  system clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- inA  input  1  channel A carry pulse; one cycle high per wrap, or continuously high for modulus 1
- inB  input  1  channel B carry pulse, same rules as inA
- modA  output  W  last measured A period in cycles
- modB  output  W  last measured B period in cycles
- validA  output  1  modA holds a completed measurement
- validB  output  1  modB holds a completed measurement
- stableA  output  1  last two A periods were equal
- stableB  output  1  last two B periods were equal
- ovfA  output  1  sticky; A gap exceeded 2^W-1 cycles
- ovfB  output  1  sticky; B gap exceeded 2^W-1 cycles
- AeqB  output  1  modA == modB
- AmB  output  1  modA > modB
- BmA  output  1  modB > modA

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, interval counters 0, both channel FSMs in WAIT_FIRST.
- Channels are independent. Simultaneous inA/inB pulses need no arbitration.
- Per-channel FSM, two states:
  - WAIT_FIRST:
    - Pulse: cnt <= 1, go to MEASURE.
    - No pulse: hold. Outputs keep their previous values.
  - MEASURE, pulse seen:
    - period <= cnt, valid <= 1, ovf <= 0, cnt <= 1.
    - stable <= (cnt == period) && valid, using the old period and old valid.
  - MEASURE, no pulse and cnt < 2^W-1: cnt <= cnt+1.
  - MEASURE, no pulse and cnt == 2^W-1: overflow.
    - ovf <= 1, valid <= 0, stable <= 0, period holds its last value, go to WAIT_FIRST.
- Timing, with pulses at cycle t0 and t0+N:
  - modX = N is visible from cycle t0+N+1.
  - inX high on consecutive cycles gives N=1.
  - Max N = 2^W-1 = 1023.
- Compare stage is registered, one cycle after the period registers, so 2 cycles after the closing pulse.
  - Evaluated only when validA && validB; otherwise AeqB = AmB = BmA = 0.
  - When evaluated, exactly one of the three is high (one-hot).
- Width: unsigned, W bits. The counter never wraps; saturation is handled by the overflow rule.
- Reset mid-measurement discards the partial count. The first pulse after reset only starts a measurement.

Decomposition:
- Shared package cout_dec_pkg holds:
  - W_DEFAULT = 10
  - typedef period_t = bit [W-1:0]
  - enum meas_state_e {WAIT_FIRST, MEASURE}
- Sub-module pulse_period_meter (CLK, rst_n, in, period, valid, stable, ovf) is instantiated twice.
- The top holds the registered three-way comparator.

Test Plan:
- Reset check: assert rst_n low mid-run, asynchronously between edges -> all outputs 0 immediately, without waiting for a CLK edge.
- Matched rates: inA and inB each pulse every 7 cycles, starting on the same cycle.
  - modA = modB = 7 and validA = validB = 1, one cycle after the second pulse.
  - AeqB = 1 one cycle after that.
  - stableA/B = 1 after the third pulse.
- Unequal rates: A every 5 cycles, B every 12 cycles.
  - modA = 5, modB = 12, then BmA = 1, AmB = 0, AeqB = 0.
  - Swap the rates -> AmB = 1.
- Modulus 1: inA held high -> modA = 1, stableA = 1 by the third cycle.
- Overflow: A pulses once, then 1023 quiet cycles.
  - ovfA = 1, validA = 0, AeqB/AmB/BmA = 0.
  - Next pulses at gap 1023 -> modA = 1023, ovfA = 0.
- Rate change: A goes from a period of 9 to a period of 4.
  - First 4-cycle gap -> modA = 4, stableA = 0.
  - Next 4-cycle gap -> stableA = 1.
